// File: rtl/spwm_pkg.sv
// Shared types and sizing for the sine-PWM sequencer.
// Build option: DEADTIME_EN inserts a dead-time state on polarity swaps.
package spwm_pkg;

  localparam int THETA_W    = 10;
  localparam int THETA_LAST = 88;
  localparam int DIV_W      = 16;
  localparam int PAUSE_W    = 20;
  localparam int DT_CYCLES  = 16;
  localparam int HALF_W     = 8;

  localparam logic [THETA_W-1:0] THETA_MAX =
    THETA_W'(THETA_LAST);
  localparam logic [PAUSE_W-1:0] DT_LAST =
    PAUSE_W'(DT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD,
    PAUSE
  } state_t;

  // A zero-length pause still occupies one cycle.
  function automatic logic [PAUSE_W-1:0] last_of(
    input logic [PAUSE_W-1:0] n
  );
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

endpackage

// File: rtl/spwm_if.sv
// Config/output bundle between the register block and the sequencer.
// master = config side, slave = sequencer.
interface spwm_if;
  import spwm_pkg::*;

  logic                en;
  logic [DIV_W-1:0]    cfg_div;
  logic [HALF_W-1:0]   cfg_cycles;
  logic [PAUSE_W-1:0]  cfg_pause;
  logic [THETA_W-1:0]  theta;
  logic                theta_vld;
  logic                leg_a;
  logic                leg_b;
  logic                busy;
  logic                done;

  modport master (
    output en, cfg_div, cfg_cycles, cfg_pause,
    input  theta, theta_vld, leg_a, leg_b, busy, done
  );

  modport slave (
    input  en, cfg_div, cfg_cycles, cfg_pause,
    output theta, theta_vld, leg_a, leg_b, busy, done
  );

endinterface

// File: rtl/spwm_tick_gen.sv
// Phase-step prescaler: one tick every div clocks (div=0 acts as 1).
// clr holds the count at zero so a fresh step starts aligned.
module spwm_tick_gen
  import spwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  assign last = (div == '0) ? '0 : div - 1'b1;
  assign tick = !clr && (cnt == last);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spwm_sequencer.sv
// Sine-PWM sequencer: theta stepping, half-cycle count, leg steering.
// Build option: DEADTIME_EN adds a DEAD state between polarities.
module spwm_sequencer
  import spwm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  spwm_if.slave bus
);

  state_t              st, st_n;
  logic [THETA_W-1:0]  theta, theta_n;
  logic                vld, vld_n;
  logic                la, la_n;
  logic                lb, lb_n;
  logic                busy, busy_n;
  logic                done, done_n;
  logic                pol, pol_n;
  logic                stop, stop_n;
  logic [HALF_W-1:0]   half, half_n;
  logic [HALF_W-1:0]   cyc, cyc_n;
  logic [DIV_W-1:0]    div, div_n;
  logic [PAUSE_W-1:0]  pause, pause_n;
  logic [PAUSE_W-1:0]  cnt, cnt_n;
  logic                go;
  logic                tick;
  logic                clr;

  assign clr = (st != RUN);

  spwm_tick_gen u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    st_n    = st;
    theta_n = theta;
    vld_n   = vld;
    la_n    = la;
    lb_n    = lb;
    done_n  = 1'b0;
    pol_n   = pol;
    stop_n  = stop;
    half_n  = half;
    cyc_n   = cyc;
    div_n   = div;
    pause_n = pause;
    cnt_n   = cnt;
    go      = 1'b0;
    unique case (st)
      IDLE: go = bus.en;
      RUN: begin
        if (!bus.en) stop_n = 1'b1;
        if (tick) begin
          if (theta != THETA_MAX) begin
            theta_n = theta + 1'b1;
          end else begin
            theta_n = '0;
            half_n  = half + 1'b1;
            if (stop || !bus.en) begin
              st_n   = IDLE;
              vld_n  = 1'b0;
              la_n   = 1'b0;
              lb_n   = 1'b0;
              done_n = 1'b1;
            end else if (cyc != '0 && half_n == cyc) begin
              st_n   = PAUSE;
              vld_n  = 1'b0;
              la_n   = 1'b0;
              lb_n   = 1'b0;
              done_n = 1'b1;
              cnt_n  = '0;
            end else begin
              pol_n = !pol;
`ifdef DEADTIME_EN
              st_n  = DEAD;
              vld_n = 1'b0;
              la_n  = 1'b0;
              lb_n  = 1'b0;
              cnt_n = '0;
`else
              la_n  = pol;
              lb_n  = !pol;
`endif
            end
          end
        end
      end
`ifdef DEADTIME_EN
      DEAD: begin
        if (!bus.en) stop_n = 1'b1;
        if (cnt == DT_LAST) begin
          st_n  = RUN;
          vld_n = 1'b1;
          la_n  = !pol;
          lb_n  = pol;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      PAUSE: begin
        if (cnt == last_of(pause)) begin
          go = bus.en;
          if (!bus.en) st_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        st_n  = IDLE;
        vld_n = 1'b0;
        la_n  = 1'b0;
        lb_n  = 1'b0;
      end
    endcase
    // Burst start: the only point where cfg is captured.
    if (go) begin
      st_n    = RUN;
      theta_n = '0;
      vld_n   = 1'b1;
      la_n    = 1'b1;
      lb_n    = 1'b0;
      pol_n   = 1'b0;
      stop_n  = 1'b0;
      half_n  = '0;
      cnt_n   = '0;
      cyc_n   = bus.cfg_cycles;
      div_n   = bus.cfg_div;
      pause_n = bus.cfg_pause;
    end
    busy_n = (st_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      theta <= '0;
      vld   <= 1'b0;
      la    <= 1'b0;
      lb    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pol   <= 1'b0;
      stop  <= 1'b0;
      half  <= '0;
      cyc   <= '0;
      div   <= '0;
      pause <= '0;
      cnt   <= '0;
    end else begin
      st    <= st_n;
      theta <= theta_n;
      vld   <= vld_n;
      la    <= la_n;
      lb    <= lb_n;
      busy  <= busy_n;
      done  <= done_n;
      pol   <= pol_n;
      stop  <= stop_n;
      half  <= half_n;
      cyc   <= cyc_n;
      div   <= div_n;
      pause <= pause_n;
      cnt   <= cnt_n;
    end
  end

  assign bus.theta     = theta;
  assign bus.theta_vld = vld;
  assign bus.leg_a     = la;
  assign bus.leg_b     = lb;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_spwm_sequencer.sv
// Bench for spwm_sequencer: expected output traces built from burst rules.
// Honours DEADTIME_EN when the design is built with it.
module tb_spwm_sequencer;
  import spwm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spwm_if bus ();

  spwm_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q [$];

  typedef struct {
    int div;
    int cycles;
    int pause;
    bit twice;
    int len;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [14:0] fr(
    int t, bit v, bit a, bit b, bit bu, bit d
  );
    logic [THETA_W-1:0] tt;
    tt = THETA_W'(t);
    return {tt, v, a, b, bu, d};
  endfunction

  function automatic logic [14:0] sample();
    return {bus.theta, bus.theta_vld, bus.leg_a,
            bus.leg_b, bus.busy, bus.done};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void push_half(int dv, bit neg);
    int dd;
    dd = (dv == 0) ? 1 : dv;
    for (int t = 0; t <= THETA_LAST; t++)
      for (int d = 0; d < dd; d++)
        exp_q.push_back(fr(t, 1, !neg, neg, 1, 0));
  endfunction

  function automatic void push_dead();
`ifdef DEADTIME_EN
    for (int k = 0; k < DT_CYCLES; k++)
      exp_q.push_back(fr(0, 0, 0, 0, 1, 0));
`endif
  endfunction

  function automatic int dead_extra(int cy);
`ifdef DEADTIME_EN
    return DT_CYCLES * (cy - 1);
`else
    return 0 * cy;
`endif
  endfunction

  function automatic void push_burst(int dv, int cy);
    for (int h = 0; h < cy; h++) begin
      push_half(dv, (h % 2) == 1);
      if (h < cy - 1) push_dead();
    end
  endfunction

  // Returns frame index of the final done pulse (where en is dropped).
  function automatic int build(int dv, int cy, int pa, bit tw);
    int drop;
    int pp;
    drop = 0;
    pp = (pa == 0) ? 1 : pa;
    for (int r = 0; r < (tw ? 2 : 1); r++) begin
      push_burst(dv, cy);
      drop = exp_q.size();
      exp_q.push_back(fr(0, 0, 0, 0, 1, 1));
      for (int k = 1; k < pp; k++)
        exp_q.push_back(fr(0, 0, 0, 0, 1, 0));
    end
    for (int k = 0; k < 3; k++) exp_q.push_back('0);
    return drop;
  endfunction

  task automatic set_cfg(input int dv, input int cy,
                         input int pa);
    bus.cfg_div    = DIV_W'(dv);
    bus.cfg_cycles = HALF_W'(cy);
    bus.cfg_pause  = PAUSE_W'(pa);
  endtask

  task automatic run_trace(input string tag, input int drop,
                           input bit scr, input int dv,
                           input int cy, input int pa,
                           output int fd);
    bit bad;
    int n;
    logic [14:0] got;
    bad = 0;
    fd = -1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = sample();
      if (!bad) begin
        checks++;
        if (got !== exp_q[i]) begin
          errors++;
          bad = 1;
          $display("FAIL %s frame %0d: got %h expected %h",
                   tag, i, got, exp_q[i]);
        end
      end
      if (got[0] === 1'b1 && fd < 0) fd = i;
      if (i == drop) bus.en = 1'b0;
      if (scr && i == 0)
        set_cfg(int'($urandom_range(1, 9)),
                int'($urandom_range(4, 9)),
                int'($urandom_range(20, 40)));
      if (scr && i == 10) set_cfg(dv, cy, pa);
    end
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drop;
    int fd;
    int dv, cy, pa;
    bit tw;
    bit hit;

    vecs[0] = '{div: 2, cycles: 2, pause: 10, twice: 1, len: 356};
    vecs[1] = '{div: 1, cycles: 1, pause: 0,  twice: 0, len: 89};
    vecs[2] = '{div: 0, cycles: 1, pause: 3,  twice: 1, len: 89};
    vecs[3] = '{div: 3, cycles: 1, pause: 1,  twice: 1, len: 267};
    vecs[4] = '{div: 1, cycles: 3, pause: 2,  twice: 0, len: 267};

    rst = 1'b1;
    bus.en = 1'b1;
    set_cfg(2, 2, 10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold", sample(), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("run_after_rst", sample(), fr(0, 1, 1, 0, 1, 0));
    bus.en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_state", sample(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", sample(), 0);

    foreach (vecs[k]) begin
      set_cfg(vecs[k].div, vecs[k].cycles, vecs[k].pause);
      bus.en = 1'b1;
      drop = build(vecs[k].div, vecs[k].cycles,
                   vecs[k].pause, vecs[k].twice);
      run_trace($sformatf("vec%0d", k), drop, 1'b1,
                vecs[k].div, vecs[k].cycles,
                vecs[k].pause, fd);
      chk($sformatf("burst_len%0d", k), fd,
          vecs[k].len + dead_extra(vecs[k].cycles));
    end

    for (int r = 0; r < 6; r++) begin
      dv = int'($urandom_range(0, 3));
      cy = int'($urandom_range(1, 3));
      pa = int'($urandom_range(0, 6));
      tw = 1'($urandom_range(0, 1));
      set_cfg(dv, cy, pa);
      bus.en = 1'b1;
      drop = build(dv, cy, pa, tw);
      run_trace($sformatf("rnd%0d", r), drop, 1'b1,
                dv, cy, pa, fd);
    end

    // Continuous run, then stop requested mid half-cycle.
    set_cfg(0, 0, 5);
    bus.en = 1'b1;
    for (int h = 0; h < 5; h++) begin
      push_half(0, (h % 2) == 1);
      push_dead();
    end
    drop = exp_q.size() + 40;
    push_half(0, 1'b1);
    exp_q.push_back(fr(0, 0, 0, 0, 0, 1));
    exp_q.push_back('0);
    exp_q.push_back('0);
    run_trace("cont_stop", drop, 1'b0, 0, 0, 5, fd);

    // Reset in the middle of a run.
    set_cfg(1, 0, 0);
    bus.en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (bus.theta == 10'd50) hit = 1'b1;
    end
    chk("theta50_reached", 32'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_run", sample(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart", sample(), fr(0, 1, 1, 0, 1, 0));
    bus.en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("final_idle", sample(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
